// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction/data) arbiter in front of one shared memory port.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-low reset
//   i_strobe/i_rw/i_address/i_wdata -> i_rdata/i_ready   instruction requester (rw: 1=read, 0=write)
//   d_strobe/d_rw/d_address/d_wdata -> d_rdata/d_ready   data requester
//   m_enable/m_read/m_write/m_address/m_wdata, m_rdata/m_ready   shared memory side
//   grant_d                       1 while the data requester owns the memory (BUSY/RESP)
//
// Configuration:
//   MEM_ARBITER_RR_EN  defined   -> round-robin on simultaneous strobes (instruction first after reset)
//                      undefined -> fixed priority, data wins
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_strobe,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_enable,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_address,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        grant_d
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;
    logic        owner_d;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        win_d;
    logic        grab;

    assign grab = (state == IDLE) & (i_strobe | d_strobe);

`ifdef MEM_ARBITER_RR_EN
    // last_i=0 after reset makes a tie go to the instruction side first
    logic last_i;
    always_ff @(posedge clock)
        if (!reset)
            last_i <= 1'b0;
        else if (grab)
            last_i <= ~win_d;
    assign win_d = d_strobe & (~i_strobe | last_i);
`else
    assign win_d = d_strobe;
`endif

    always_ff @(posedge clock)
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge clock)
        if (!reset) begin
            owner_d <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grab) begin
                owner_d <= win_d;
                rw_q    <= win_d ? d_rw : i_rw;
                addr_q  <= win_d ? d_address : i_address;
                wdata_q <= win_d ? d_wdata : i_wdata;
            end
            // captured for reads and writes alike
            if (state == BUSY && m_ready) begin
                if (owner_d)
                    d_rdata <= m_rdata;
                else
                    i_rdata <= m_rdata;
            end
        end

    always_comb begin
        state_next = (state == IDLE) ? (grab ? BUSY : IDLE) :
                     (state == BUSY) ? (m_ready ? RESP : BUSY) : IDLE;
        m_enable   = state == BUSY;
        m_read     = m_enable & rw_q;
        m_write    = m_enable & ~rw_q;
        m_address  = m_enable ? addr_q : '0;
        m_wdata    = m_enable ? wdata_q : '0;
        i_ready    = (state == RESP) & ~owner_d;
        d_ready    = (state == RESP) & owner_d;
        grant_d    = (state != IDLE) & owner_d;
    end
endmodule
